// File: rtl/acq_pkg.sv
// acq_pkg: shared state encoding and counter width for the acquisition sequencer
package acq_pkg;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RESET    = 3'd1,
    ST_CLKSW    = 3'd2,
    ST_LOCKWAIT = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_RUN      = 3'd5,
    ST_STOP     = 3'd6,
    ST_ERROR    = 3'd7
  } state_t;
endpackage

// File: rtl/down_counter.sv
// down_counter: loadable saturating down-counter with zero flag
module down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;
  // load has priority; decrement stops at zero
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else count <= load ? load_val : (en && count != '0) ? count - 1'b1 : count;
  assign zero = count == '0;
endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer: capture-session sequencer (reset, optional clock switch, settle, run, stop)
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 64,
  parameter int STOP_CYCLES   = 8,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clock_select_req,
  input  logic       clk_locked,
  input  logic       fifo_overflow,
  input  logic       clear_overflow,
  output logic       acq_enable,
  output logic       acq_reset,
  output logic       clock_select,
  output logic       clkgen_rst,
  output logic       running,
  output logic       busy,
  output logic       error,
  output logic       overflow_sticky,
  output logic [2:0] state_out
);
  localparam int MAX_CNT = 2 ** CNT_W - 1;
  localparam logic [CNT_W-1:0] RESET_LD  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LD   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STOP_LD   = CNT_W'(STOP_CYCLES - 1);

  if (RESET_CYCLES < 2 || LOCK_TIMEOUT < 1 || SETTLE_CYCLES < 1 || STOP_CYCLES < 1 ||
      RESET_CYCLES > MAX_CNT || LOCK_TIMEOUT > MAX_CNT ||
      SETTLE_CYCLES > MAX_CNT || STOP_CYCLES > MAX_CNT) begin : g_cfg_err
    $error("acq_sequencer: cycle parameter out of range for CNT_W");
  end

  state_t state, nxt;
  logic sel_next, load, take_sel, do_switch, zero;
  logic [CNT_W-1:0] load_val;

  down_counter #(.W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .load(load), .en(1'b1), .load_val(load_val), .zero(zero)
  );

  // state register
  always_ff @(posedge clk)
    if (rst) state <= ST_IDLE;
    else state <= nxt;

  // next state and counter reloads; stop preempts every active pre-run/run state
  always_comb begin
    nxt       = state;
    load      = 1'b0;
    load_val  = '0;
    take_sel  = 1'b0;
    do_switch = 1'b0;
    if (stop && state inside {ST_RESET, ST_CLKSW, ST_LOCKWAIT, ST_SETTLE, ST_RUN}) begin
      nxt      = ST_STOP;
      load     = 1'b1;
      load_val = STOP_LD;
    end else begin
      unique case (state)
        ST_IDLE:
          if (start && !stop) begin
            nxt      = ST_RESET;
            load     = 1'b1;
            load_val = RESET_LD;
            take_sel = 1'b1;
          end
        ST_RESET:
          if (zero) begin
            load = 1'b1;
            if (sel_next != clock_select) begin
              nxt       = ST_CLKSW;
              load_val  = RESET_LD;
              do_switch = 1'b1;
            end else begin
              nxt      = ST_SETTLE;
              load_val = SETTLE_LD;
            end
          end
        ST_CLKSW:
          if (zero) begin
            nxt      = ST_LOCKWAIT;
            load     = 1'b1;
            load_val = LOCK_LD;
          end
        ST_LOCKWAIT:
          if (clk_locked) begin
            nxt      = ST_SETTLE;
            load     = 1'b1;
            load_val = SETTLE_LD;
          end else if (zero) nxt = ST_ERROR;
        ST_SETTLE: nxt = zero ? ST_RUN : ST_SETTLE;
        ST_RUN:    nxt = ST_RUN;
        ST_STOP:   nxt = zero ? ST_IDLE : ST_STOP;
        ST_ERROR:  nxt = (start || stop) ? ST_IDLE : ST_ERROR;
      endcase
    end
  end

  // registered outputs decoded from the state being entered; overflow set beats clear
  always_ff @(posedge clk)
    if (rst) begin
      acq_enable      <= 1'b0;
      acq_reset       <= 1'b1;
      clkgen_rst      <= 1'b0;
      clock_select    <= 1'b0;
      sel_next        <= 1'b0;
      overflow_sticky <= 1'b0;
    end else begin
      acq_enable      <= nxt == ST_RUN;
      acq_reset       <= !(nxt inside {ST_SETTLE, ST_RUN, ST_STOP});
      clkgen_rst      <= nxt == ST_CLKSW;
      clock_select    <= do_switch ? sel_next : clock_select;
      sel_next        <= take_sel ? clock_select_req : sel_next;
      overflow_sticky <= (state == ST_RUN && fifo_overflow) || (overflow_sticky && !clear_overflow);
    end

  assign running   = state == ST_RUN;
  assign busy      = !(state inside {ST_IDLE, ST_ERROR});
  assign error     = state == ST_ERROR;
  assign state_out = state;
endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: scoreboard bench for the acquisition sequencer
module tb_acq_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, req = 1'b0;
  logic lock = 1'b0, fo = 1'b0, co = 1'b0;
  logic r_n = 1'b1, lk = 1'b0;
  logic acq_enable, acq_reset, clock_select, clkgen_rst, running, busy, error, overflow_sticky;
  logic [2:0] state_out;

  typedef struct {
    int          id;
    logic [10:0] v;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int vectors = 0, miscompares = 0, nid = 0;

  acq_sequencer #(
    .RESET_CYCLES(4), .LOCK_TIMEOUT(20), .SETTLE_CYCLES(6), .STOP_CYCLES(3), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clock_select_req(req),
    .clk_locked(lock), .fifo_overflow(fo), .clear_overflow(co),
    .acq_enable(acq_enable), .acq_reset(acq_reset), .clock_select(clock_select),
    .clkgen_rst(clkgen_rst), .running(running), .busy(busy), .error(error),
    .overflow_sticky(overflow_sticky), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // expected output word for a state: {state, en, rst, sel, clkgen, run, busy, err, ovf}
  function automatic logic [10:0] expv(input logic [2:0] st, input logic cs, input logic ov);
    return {st, st == 3'd5, st inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd7}, cs, st == 3'd2,
            st == 3'd5, !(st == 3'd0 || st == 3'd7), st == 3'd7, ov};
  endfunction

  // drive one cycle of inputs and queue the outputs expected after the next edge
  task automatic t(input logic s, input logic p, input logic rq, input logic f, input logic c,
                   input logic [2:0] st, input logic cs, input logic ov);
    @(negedge clk);
    rst = r_n; start = s; stop = p; req = rq; fo = f; co = c; lock = lk;
    q.push_back('{nid, expv(st, cs, ov)});
    nid++;
    @(posedge clk);
  endtask

  task automatic rep(input int n, input logic [2:0] st, input logic cs, input logic ov);
    for (int i = 0; i < n; i++) t(0, 0, 0, 0, 0, st, cs, ov);
  endtask

  // monitor: compare one queued expectation per cycle, just after the edge
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if ({state_out, acq_enable, acq_reset, clock_select, clkgen_rst, running, busy, error,
           overflow_sticky} !== e.v) begin
        miscompares++;
        $display("FAIL vec %0d: got st=%0d en/rs/cs/cg/run/busy/err/ov=%b, expected st=%0d bits=%b",
                 e.id, state_out, {acq_enable, acq_reset, clock_select, clkgen_rst, running, busy,
                 error, overflow_sticky}, e.v[10:8], e.v[7:0]);
      end
    end
  end

  initial begin
    rep(2, 0, 0, 0);
    r_n = 1'b0;
    // same-clock session
    t(1, 0, 0, 0, 0, 1, 0, 0); rep(3, 1, 0, 0); rep(6, 4, 0, 0); rep(1, 5, 0, 0);
    t(1, 0, 0, 0, 0, 5, 0, 0);
    t(0, 0, 0, 1, 0, 5, 0, 1); rep(1, 5, 0, 1);
    t(0, 0, 0, 1, 1, 5, 0, 1);
    t(0, 0, 0, 0, 1, 5, 0, 0);
    t(1, 1, 0, 0, 0, 6, 0, 0); rep(2, 6, 0, 0); rep(1, 0, 0, 0);
    t(0, 0, 0, 1, 0, 0, 0, 0);
    t(1, 1, 0, 0, 0, 0, 0, 0);
    // clock switch with lock after 5 LOCKWAIT cycles
    t(1, 0, 1, 0, 0, 1, 0, 0); rep(3, 1, 0, 0); rep(4, 2, 1, 0); rep(5, 3, 1, 0);
    lk = 1'b1;
    t(0, 0, 0, 0, 0, 4, 1, 0); rep(5, 4, 1, 0); rep(1, 5, 1, 0);
    lk = 1'b0;
    t(0, 1, 0, 0, 0, 6, 1, 0); rep(2, 6, 1, 0); rep(1, 0, 1, 0);
    // lock timeout switching back to normal clock
    t(1, 0, 0, 0, 0, 1, 1, 0); rep(3, 1, 1, 0); rep(4, 2, 0, 0); rep(20, 3, 0, 0); rep(2, 7, 0, 0);
    t(0, 1, 0, 0, 0, 0, 0, 0);
    // abort during CLKSW
    t(1, 0, 1, 0, 0, 1, 0, 0); rep(3, 1, 0, 0); rep(2, 2, 1, 0);
    t(0, 1, 0, 0, 0, 6, 1, 0); rep(2, 6, 1, 0); rep(1, 0, 1, 0);
    // abort during SETTLE, no clock change needed
    t(1, 0, 1, 0, 0, 1, 1, 0); rep(3, 1, 1, 0); rep(2, 4, 1, 0);
    t(0, 1, 0, 0, 0, 6, 1, 0); rep(2, 6, 1, 0); rep(1, 0, 1, 0);
    // reset mid-RUN
    t(1, 0, 1, 0, 0, 1, 1, 0); rep(3, 1, 1, 0); rep(6, 4, 1, 0); rep(1, 5, 1, 0);
    t(0, 0, 0, 1, 0, 5, 1, 1);
    r_n = 1'b1;
    t(0, 0, 0, 0, 0, 0, 0, 0);
    r_n = 1'b0;
    rep(1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
- Sequences one capture session in the normal clock domain: acquisition reset, optional sample-clock switch with clock-generator reset and lock wait, settle time, acquisition enable, and an orderly stop.
- Inputs are start/stop strobes and clock-select requests from the SPI register block.
- Outputs drive the acq_enable/acq_reset/clock_select lines that are synchronized into the fast clock domain, plus the clock-generator reset.
- Reports status and a sticky FIFO-overflow flag back to the register block.

Parameters:
- RESET_CYCLES, 16: clk cycles acq_reset is held in RESET, and clkgen_rst is held in CLKSW (≥2).
- LOCK_TIMEOUT, 65535: max clk cycles spent in LOCKWAIT before ERROR.
- SETTLE_CYCLES, 64: clk cycles between acq_reset release and acq_enable (covers the synchronizer plus FIFO reset recovery).
- STOP_CYCLES, 8: clk cycles acq_enable is held low before returning to IDLE.
- CNT_W, 16: width of the shared down-counter; must hold the largest of the above.

Ports:
- clk  in  1  normal clock domain clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle strobe: begin session
- stop  in  1  one-cycle strobe: end or abort session
- clock_select_req  in  1  requested sample clock (0 = normal, 1 = fast); sampled on accepted start only
- clk_locked  in  1  clock-generator lock, already synchronized to clk
- fifo_overflow  in  1  FIFO overflow level/pulse, already synchronized to clk
- clear_overflow  in  1  one-cycle strobe: clear overflow_sticky
- acq_enable  out  1  sampling enable toward fast domain
- acq_reset  out  1  fast-domain/FIFO reset
- clock_select  out  1  clock mux select
- clkgen_rst  out  1  clock-generator reset request, ORed externally with global reset
- running  out  1  high exactly in RUN
- busy  out  1  high in any state except IDLE and ERROR
- error  out  1  high in ERROR (lock timeout)
- overflow_sticky  out  1  set by fifo_overflow while in RUN
- state_out  out  3  current state encoding, for the status register

Behaviour:
- On rst:
  - state = IDLE.
  - acq_enable = 0, acq_reset = 1, clock_select = 0, clkgen_rst = 0.
  - overflow_sticky = 0, counter = 0.
- Registered Moore outputs; all outputs change on the clk edge that enters the new state.
- State encoding: IDLE=0, RESET=1, CLKSW=2, LOCKWAIT=3, SETTLE=4, RUN=5, STOP=6, ERROR=7.
- IDLE:
  - acq_reset = 1, acq_enable = 0.
  - start (with stop low) → RESET; latch clock_select_req into sel_next; counter = RESET_CYCLES-1.
- RESET:
  - acq_reset = 1; count down.
  - At 0: if sel_next ≠ clock_select → CLKSW, clock_select ← sel_next, counter = RESET_CYCLES-1.
  - Otherwise → SETTLE, counter = SETTLE_CYCLES-1.
- CLKSW:
  - clkgen_rst = 1, acq_reset = 1.
  - At 0 → LOCKWAIT, clkgen_rst = 0, counter = LOCK_TIMEOUT-1.
- LOCKWAIT:
  - acq_reset = 1.
  - clk_locked = 1 → SETTLE, counter = SETTLE_CYCLES-1.
  - Counter reaches 0 with lock still low → ERROR.
  - If lock and timeout land on the same cycle, lock wins.
- SETTLE:
  - acq_reset = 0, acq_enable = 0.
  - At 0 → RUN, acq_enable = 1.
- RUN:
  - acq_enable = 1, running = 1.
  - fifo_overflow = 1 sets overflow_sticky.
- STOP:
  - acq_enable = 0, acq_reset = 0; count STOP_CYCLES-1 down.
  - At 0 → IDLE; acq_reset reasserts on entry to IDLE.
- ERROR:
  - acq_reset = 1, acq_enable = 0, error = 1.
  - stop or start → IDLE. A start here does not auto-retry.
- stop handling:
  - stop in RESET, CLKSW, LOCKWAIT, SETTLE or RUN → STOP, counter = STOP_CYCLES-1.
  - CLKSW abort also drops clkgen_rst that cycle.
- start handling: start in any state except IDLE and ERROR is ignored.
- start and stop on the same cycle: stop wins. In IDLE, nothing happens.
- clear_overflow and fifo_overflow on the same cycle: set wins.
- clock_select holds its value across sessions; it changes only in the RESET→CLKSW transition.
- rst asserted mid-session forces reset values on the next edge. clock_select returns to 0; this is acceptable because the global reset also resets the clock generator.
- Counter width: truncation of parameters larger than 2^CNT_W-1 is a configuration error, checked by an elaboration assertion.

Decomposition:
- Shared package (acq_pkg):
  - state encoding constants ST_IDLE..ST_ERROR, 3 bits; the register block decodes state_out with them.
  - CNT_W default.
- One sub-module, down_counter: load/enable/zero-flag, width CNT_W.
- The FSM and output registers stay in acq_sequencer.

Test Plan:
- Parameters: RESET_CYCLES=4, SETTLE_CYCLES=6, STOP_CYCLES=3, LOCK_TIMEOUT=20.
- Same-clock start: start with req=0, clock_select=0 → acq_reset high 4 cycles; then 6 cycles low with acq_enable=0; acq_enable=1 on cycle 11 after start; CLKSW never entered; clkgen_rst never high.
- Clock switch: start with req=1 → clkgen_rst high exactly 4 cycles after RESET; clock_select=1 from CLKSW entry; raise clk_locked 5 cycles into LOCKWAIT → SETTLE next cycle, RUN 6 cycles later.
- Lock timeout: start with req=1, clk_locked held 0 → ERROR after 20 LOCKWAIT cycles; error=1, state_out=7, busy=0; stop → IDLE, error=0.
- Abort and collisions: stop during SETTLE → acq_enable stays 0, STOP for 3 cycles, then IDLE with acq_reset=1; start+stop same cycle in RUN → STOP; start in RUN alone → ignored.
- Overflow: 1-cycle fifo_overflow in RUN → overflow_sticky=1 until clear_overflow; overflow+clear same cycle → stays 1; fifo_overflow in IDLE → no set.
- Reset mid-RUN: rst pulse → next edge acq_enable=0, acq_reset=1, clock_select=0, state_out=0, overflow_sticky=0.
